// File: rtl/sketch_hot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sketch_hot_pkg
// Brief    : Shared types, constants and helpers for the count-min sketch
//            hot-address filter.
// Revision : 1.0 - initial release
// ============================================================================
package sketch_hot_pkg;

    // Default field widths of a hot entry
    localparam int c_HOT_ADDR_W = 22;
    localparam int c_HOT_CNT_W  = 32;

    // Working width of the min2 helper; narrower counters are zero-extended
    localparam int c_MIN_W = 64;

    // Saturation value of 32-bit event counters
    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    // One hot FIFO entry: address and its count-min estimate
    typedef struct packed {
        logic [c_HOT_ADDR_W-1:0] addr;
        logic [c_HOT_CNT_W-1:0]  cnt;
    } hot_entry_t;

    // Unsigned minimum of two counts
    function automatic logic [c_MIN_W-1:0] min2(input logic [c_MIN_W-1:0] a,
                                                 input logic [c_MIN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hot_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hot_addr_fifo
// Brief    : Synchronous FIFO parameterised on entry type and depth. Pointers
//            carry one extra wrap bit so full and empty are told apart.
// Revision : 1.0 - initial release
// ============================================================================
module hot_addr_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  T                         push_data,
    output logic                     full,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_PTR_W = $clog2(DEPTH) + 1;
    localparam int c_IDX_W = c_PTR_W - 1;

    T                   r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    // Full when the wrap bits differ and the index bits match
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                   (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;

    // A pop on a full FIFO frees the slot the push lands in
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Head is forced to zero when empty so stale storage never shows
    assign pop_data = empty ? T'('0) : r_mem[r_rd_ptr[c_IDX_W-1:0]];

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_IDX_W-1:0]] <= push_data;
        end
    end

    // Pointer advance on accepted push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sketch_hot_filter.sv
`default_nettype none
// ============================================================================
// Module   : sketch_hot_filter
// Brief    : Reduces each sketch beat to its count-min estimate, qualifies it
//            against a threshold, suppresses back-to-back duplicate addresses
//            and queues hot addresses; beats finding the queue full are
//            dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module sketch_hot_filter
    import sketch_hot_pkg::*;
#(
    parameter int NUM_HASH   = 4,
    parameter int ADDR_SIZE  = c_HOT_ADDR_W,
    parameter int CNT_SIZE   = c_HOT_CNT_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [ADDR_SIZE-1:0]          in_addr,
    input  logic [CNT_SIZE-1:0]           in_cnt_array [0:NUM_HASH-1],
    input  logic [CNT_SIZE-1:0]           threshold,
    output logic                          hot_valid,
    input  logic                          hot_ready,
    output logic [ADDR_SIZE-1:0]          hot_addr,
    output logic [CNT_SIZE-1:0]           hot_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   drop_cnt
);

    localparam int c_LEVELS = $clog2(NUM_HASH);
    localparam int c_LVL_W  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [CNT_SIZE-1:0]  cnt;
    } entry_t;

    // S1 registers
    logic                 r_s1_vld;
    logic [ADDR_SIZE-1:0] r_s1_addr;
    logic [CNT_SIZE-1:0]  r_s1_min;

    // Duplicate tracking and drop accounting
    logic                 r_last_vld;
    logic [ADDR_SIZE-1:0] r_last_addr;
    logic [31:0]          r_drop_cnt;

    logic [CNT_SIZE-1:0]  w_min;
    logic                 w_hot;
    logic                 w_dup;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_LVL_W-1:0]   w_level;
    entry_t               w_push_data;
    entry_t               w_head;

    // Balanced unsigned min tree: level 0 holds the raw counts, each further
    // level halves the width until a single minimum remains
    generate
        for (genvar l = 0; l <= c_LEVELS; l++) begin : g_lvl
            logic [CNT_SIZE-1:0] w_v [0:(NUM_HASH >> l)-1];
            for (genvar k = 0; k < (NUM_HASH >> l); k++) begin : g_k
                if (l == 0) begin : g_leaf
                    assign w_v[k] = in_cnt_array[k];
                end else begin : g_cmp
                    assign w_v[k] = CNT_SIZE'(min2(c_MIN_W'(g_lvl[l-1].w_v[2*k]),
                                                   c_MIN_W'(g_lvl[l-1].w_v[2*k+1])));
                end
            end
        end
    endgenerate

    assign w_min = g_lvl[c_LEVELS].w_v[0];

    // S1: capture beat and its minimum; data holds while no beat arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_min  <= '0;
        end else begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_addr <= in_addr;
                r_s1_min  <= w_min;
            end
        end
    end

    // S2: qualify, dedup, and decide push versus drop
    assign w_hot      = r_s1_vld && (r_s1_min >= threshold);
    assign w_dup      = r_last_vld && (r_s1_addr == r_last_addr);
    assign w_push_req = w_hot && !w_dup;
    assign w_pop      = hot_valid && hot_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_push_data.addr = r_s1_addr;
    assign w_push_data.cnt  = r_s1_min;

    hot_addr_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .full      (w_full),
        .pop       (w_pop),
        .pop_data  (w_head),
        .empty     (w_empty),
        .level     (w_level)
    );

    assign hot_valid  = !w_empty;
    assign hot_addr   = w_head.addr;
    assign hot_cnt    = w_head.cnt;
    assign fifo_level = w_level;
    assign drop_cnt   = r_drop_cnt;

    // Remember the last pushed address; forget it once a pop empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_vld  <= 1'b0;
            r_last_addr <= '0;
        end else if (w_push) begin
            r_last_vld  <= 1'b1;
            r_last_addr <= r_s1_addr;
        end else if (w_pop && (w_level == c_LVL_W'(1))) begin
            r_last_vld  <= 1'b0;
        end
    end

    // Saturating count of hot beats rejected by a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != CNT_SAT)) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sketch_hot_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sketch_hot_filter
// Brief    : Scoreboard bench for sketch_hot_filter with directed beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sketch_hot_filter;
    import sketch_hot_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [21:0] in_addr;
    logic [31:0] in_cnt_array [0:3];
    logic [31:0] threshold;
    logic        hot_valid;
    logic        hot_ready;
    logic [21:0] hot_addr;
    logic [31:0] hot_cnt;
    logic [4:0]  fifo_level;
    logic [31:0] drop_cnt;

    int          total;
    int          bad;
    hot_entry_t  sb [$];

    sketch_hot_filter #(
        .NUM_HASH   (4),
        .ADDR_SIZE  (22),
        .CNT_SIZE   (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_cnt_array (in_cnt_array),
        .threshold    (threshold),
        .hot_valid    (hot_valid),
        .hot_ready    (hot_ready),
        .hot_addr     (hot_addr),
        .hot_cnt      (hot_cnt),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One beat presented for exactly one capture edge
    task automatic send(input logic [21:0] a, input logic [31:0] c0, input logic [31:0] c1,
                        input logic [31:0] c2, input logic [31:0] c3);
        in_valid        = 1'b1;
        in_addr         = a;
        in_cnt_array[0] = c0;
        in_cnt_array[1] = c1;
        in_cnt_array[2] = c2;
        in_cnt_array[3] = c3;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_push(input logic [21:0] a, input logic [31:0] m);
        hot_entry_t e;
        e.addr = a;
        e.cnt  = m;
        sb.push_back(e);
    endtask

    // Pop everything; the monitor checks each popped entry
    task automatic drain();
        hot_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (fifo_level == 5'd0) break;
            tick();
        end
        hot_ready = 1'b0;
        chk("drain_done", 64'(fifo_level), 64'd0);
    endtask

    // Monitor: every pop is compared against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && hot_valid && hot_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got addr 0x%0h cnt 0x%0h expected none", hot_addr, hot_cnt);
            end else begin
                hot_entry_t e;
                e = sb.pop_front();
                if (hot_addr !== e.addr || hot_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL sb_pop: got addr 0x%0h cnt 0x%0h expected addr 0x%0h cnt 0x%0h",
                             hot_addr, hot_cnt, e.addr, e.cnt);
                end
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        threshold = 32'd3;
        hot_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_cnt_array[i] = '0;
        tick();
        tick();
        chk("rst_hot_valid", 64'(hot_valid), 64'd0);
        chk("rst_hot_addr", 64'(hot_addr), 64'd0);
        chk("rst_hot_cnt", 64'(hot_cnt), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single beat, threshold 3: min 3 is hot, appears one cycle after capture
        expect_push(22'h02A, 32'd3);
        send(22'h02A, 32'd7, 32'd3, 32'd9, 32'd5);
        chk("lat_not_yet", 64'(hot_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(hot_valid), 64'd1);
        chk("lat_addr", 64'(hot_addr), 64'h02A);
        chk("lat_cnt", 64'(hot_cnt), 64'd3);
        chk("lat_level", 64'(fifo_level), 64'd1);
        hot_ready = 1'b1;
        tick();
        hot_ready = 1'b0;
        chk("pop_empty", 64'(hot_valid), 64'd0);

        // Same beat, threshold 4: cold, no output, no drop
        threshold = 32'd4;
        send(22'h02A, 32'd7, 32'd3, 32'd9, 32'd5);
        tick();
        tick();
        chk("cold_valid", 64'(hot_valid), 64'd0);
        chk("cold_drop", 64'(drop_cnt), 64'd0);
        threshold = 32'd3;

        // Dedup: three back-to-back hits on 0x155 make one entry
        expect_push(22'h155, 32'd10);
        send(22'h155, 32'd10, 32'd11, 32'd12, 32'd13);
        send(22'h155, 32'd10, 32'd11, 32'd12, 32'd13);
        send(22'h155, 32'd10, 32'd11, 32'd12, 32'd13);
        tick();
        chk("dedup_level", 64'(fifo_level), 64'd1);
        chk("dedup_drop", 64'(drop_cnt), 64'd0);
        hot_ready = 1'b1;
        tick();
        hot_ready = 1'b0;
        chk("dedup_popped", 64'(fifo_level), 64'd0);
        expect_push(22'h155, 32'd10);
        send(22'h155, 32'd10, 32'd11, 32'd12, 32'd13);
        tick();
        chk("dedup_reenter", 64'(fifo_level), 64'd1);
        hot_ready = 1'b1;
        tick();
        hot_ready = 1'b0;

        // Full FIFO: 20 distinct hot addresses, first 16 kept, 4 dropped
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_push(22'h100 + 22'(i), 32'd50 + 32'(i));
            send(22'h100 + 22'(i), 32'd50 + 32'(i), 32'd90, 32'd90, 32'd90);
        end
        tick();
        chk("full_level", 64'(fifo_level), 64'd16);
        chk("full_drop", 64'(drop_cnt), 64'd4);

        // Full with a pop on the push edge: push accepted, level and drops hold
        expect_push(22'h200, 32'd8);
        send(22'h200, 32'd9, 32'd8, 32'd8, 32'd20);
        hot_ready = 1'b1;
        tick();
        hot_ready = 1'b0;
        chk("fullpop_level", 64'(fifo_level), 64'd16);
        chk("fullpop_drop", 64'(drop_cnt), 64'd4);
        drain();

        // Saturation: refill, preload drops near the top, cause 3 more drops
        for (int i = 0; i < 16; i++) begin
            expect_push(22'h300 + 22'(i), 32'd4);
            send(22'h300 + 22'(i), 32'd4, 32'd5, 32'd6, 32'd7);
        end
        tick();
        chk("sat_level", 64'(fifo_level), 64'd16);
        force dut.r_drop_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_drop_cnt;
        send(22'h3F0, 32'd5, 32'd5, 32'd5, 32'd5);
        send(22'h3F1, 32'd5, 32'd5, 32'd5, 32'd5);
        send(22'h3F2, 32'd5, 32'd5, 32'd5, 32'd5);
        tick();
        chk("sat_drop", 64'(drop_cnt), 64'hFFFF_FFFF);
        drain();

        // Reset mid-stream with 5 queued entries and a beat in S1
        for (int i = 0; i < 5; i++) begin
            expect_push(22'h400 + 22'(i), 32'd6);
            send(22'h400 + 22'(i), 32'd6, 32'd6, 32'd6, 32'd6);
        end
        tick();
        chk("pre_rst_level", 64'(fifo_level), 64'd5);
        send(22'h4FF, 32'd9, 32'd9, 32'd9, 32'd9);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(hot_valid), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        chk("mid_rst_addr", 64'(hot_addr), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 64'(hot_valid), 64'd0);
        expect_push(22'h4AA, 32'd20);
        send(22'h4AA, 32'd40, 32'd20, 32'd30, 32'd50);
        chk("post_rst_lat0", 64'(hot_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(hot_valid), 64'd1);
        chk("post_rst_addr", 64'(hot_addr), 64'h4AA);
        chk("post_rst_cnt", 64'(hot_cnt), 64'd20);
        drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
